fpga_pad_filter: RTL

FPGA_PAD_FILTER -- requirements
Module: fpga_pad_filter

---
 rtl/fpga_pad_filter.sv | 99 +++++++++
 1 files changed

// File: rtl/fpga_pad_filter.sv
// Per-channel pad conditioning: synchroniser followed by SYNC / DEBOUNCE / HOLD filtering,
// with single-cycle rise/fall pulses and a delayed any-edge summary.
module fpga_pad_filter #(
    parameter int unsigned      N_CH        = 48,
    parameter int unsigned      CNT_W       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [N_CH-1:0]  RST_VAL     = '1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [N_CH-1:0]     pad_i,
    input  logic [2*N_CH-1:0]   mode_i,
    input  logic [CNT_W-1:0]    thresh_i,
    output logic [N_CH-1:0]     pad_o,
    output logic [N_CH-1:0]     rise_o,
    output logic [N_CH-1:0]     fall_o,
    output logic                edge_any_o
);

    typedef enum logic [1:0] {
        MODE_SYNC     = 2'b00,
        MODE_DEBOUNCE = 2'b01,
        MODE_HOLD     = 2'b10,
        MODE_SYNC_ALT = 2'b11
    } mode_e;

    logic [N_CH-1:0]   sync_q [SYNC_STAGES];
    logic [N_CH-1:0]   s;
    logic [N_CH-1:0]   pad_q;
    logic [N_CH-1:0]   rise_q;
    logic [N_CH-1:0]   fall_q;
    logic [N_CH-1:0]   upd;
    logic              edge_q;
    logic [2*N_CH-1:0] mode_q;
    logic [CNT_W-1:0]  cnt_q [N_CH];
    logic [CNT_W-1:0]  cnt_d [N_CH];
    logic [CNT_W-1:0]  t_m1;

    assign s    = sync_q[SYNC_STAGES-1];
    // thresh_i == 0 behaves as a threshold of 1, so the terminal count is 0 either way.
    assign t_m1 = (thresh_i == '0) ? '0 : thresh_i - CNT_W'(1);

    always_comb begin
        for (int unsigned ch = 0; ch < N_CH; ch++) begin
            upd[ch]   = 1'b0;
            cnt_d[ch] = '0;
            case (mode_e'(mode_i[2*ch +: 2]))
                MODE_HOLD: begin
                end
                MODE_DEBOUNCE: begin
                    // The edge on which a new mode is first seen only clears the count.
                    if ((mode_i[2*ch +: 2] == mode_q[2*ch +: 2]) && (s[ch] != pad_q[ch])) begin
                        if (cnt_q[ch] >= t_m1) begin
                            upd[ch] = 1'b1;
                        end else begin
                            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    upd[ch] = s[ch] ^ pad_q[ch];
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
            for (int unsigned ch = 0; ch < N_CH; ch++) begin
                cnt_q[ch] <= '0;
            end
            pad_q  <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            edge_q <= 1'b0;
            mode_q <= mode_i;
        end else begin
            sync_q[0] <= pad_i;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            cnt_q  <= cnt_d;
            pad_q  <= pad_q ^ upd;
            rise_q <= upd & s;
            fall_q <= upd & ~s;
            edge_q <= |(rise_q | fall_q);
            mode_q <= mode_i;
        end
    end

    assign pad_o      = pad_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;
    assign edge_any_o = edge_q;

endmodule
